// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared state, opcode and select-code definitions for the multicycle RV32I control
package riscv_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// rtl/instret_counter.sv - wrapping retired-instruction counter
module instret_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multicycle RV32I core
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             Branch,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUop,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret
);

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal_op;
    logic   w_decode_illegal;
    logic   w_retire;
    logic   w_unused;

    // The zero flag is consumed by the datapath's branch logic, not here.
    assign w_unused = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RESET;
            r_illegal_op <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_illegal_op <= w_decode_illegal;
        end
    end

    always_comb begin
        w_next_state     = S_FETCH;
        w_decode_illegal = 1'b0;
        w_retire         = 1'b0;
        mem_req          = 1'b0;
        AdrSrc           = 1'b0;
        IRWrite          = 1'b0;
        PCUpdate         = 1'b0;
        RegWrite         = 1'b0;
        MemWrite         = 1'b0;
        Branch           = 1'b0;
        ALUSrcA          = SRCA_PC;
        ALUSrcB          = SRCB_RS2;
        ResultSrc        = RES_ALUOUT;
        ALUop            = ALUOP_ADD;

        case (r_state)
            S_RESET: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                IRWrite      = mem_ready;
                PCUpdate     = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BEQ;
                    OP_JAL:            w_next_state = S_JAL;
                    default: begin
                        w_next_state     = S_FETCH;
                        w_decode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_IMM;
                w_next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req      = 1'b1;
                AdrSrc       = 1'b1;
                w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc    = RES_MEMDATA;
                RegWrite     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req      = 1'b1;
                AdrSrc       = 1'b1;
                MemWrite     = mem_ready;
                w_retire     = mem_ready;
                w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA      = SRCA_RS1;
                ALUop        = ALUOP_R;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_IMM;
                ALUop        = ALUOP_I;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = SRCA_RS1;
                ALUop        = ALUOP_SUB;
                Branch       = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                PCUpdate     = 1'b1;
                w_next_state = S_ALUWB;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign illegal_op = r_illegal_op;

    instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_retire),
        .count (instret)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed cycle-by-cycle checks of the multicycle control FSM
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUop;
    logic        illegal_op;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCUpdate   (PCUpdate),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUop      (ALUop),
        .illegal_op (illegal_op),
        .instret    (instret)
    );

    // Field order: mem_req AdrSrc IRWrite PCUpdate RegWrite MemWrite Branch SrcA SrcB Result ALUop illegal
    logic [15:0] w_obs;
    assign w_obs = {mem_req, AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch,
                    ALUSrcA, ALUSrcB, ResultSrc, ALUop, illegal_op};

    function automatic logic [15:0] pk(input logic mr, input logic ad, input logic irw,
                                       input logic pcu, input logic rw, input logic mw,
                                       input logic br, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [1:0] op, input logic il);
        return {mr, ad, irw, pcu, rw, mw, br, sa, sb, rs, op, il};
    endfunction

    function automatic logic [15:0] e_fetch(input logic r, input logic il);
        return pk(1, 0, r, r, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, il);
    endfunction
    function automatic logic [15:0] e_decode();
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [15:0] e_memadr();
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [15:0] e_memread();
        return pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [15:0] e_memwb();
        return pk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
    endfunction
    function automatic logic [15:0] e_memwrite(input logic r);
        return pk(1, 1, 0, 0, 0, r, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [15:0] e_execr();
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0);
    endfunction
    function automatic logic [15:0] e_execi();
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b11, 0);
    endfunction
    function automatic logic [15:0] e_aluwb();
        return pk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [15:0] e_beq();
        return pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b01, 0);
    endfunction
    function automatic logic [15:0] e_jal();
        return pk(0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
    endfunction

    task automatic chk_sig(input string tag, input logic [15:0] exp);
        n_cmp++;
        assert (w_obs === exp) else begin
            n_fail++;
            $error("FAIL %s outputs: observed %b expected %b", tag, w_obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp);
        n_cmp++;
        assert (instret === exp) else begin
            n_fail++;
            $error("FAIL %s instret: observed %0d expected %0d", tag, instret, exp);
        end
    endtask

    // One clock cycle: apply mem_ready, check the settled outputs, advance past the next edge.
    task automatic cyc(input string tag, input logic ready, input logic [15:0] exp,
                       input logic [31:0] ir);
        mem_ready = ready;
        #1;
        chk_sig(tag, exp);
        chk_cnt(tag, ir);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_sig("in_reset", 16'd0);
        chk_cnt("in_reset", 32'd0);
        rst_n = 1'b1;

        // R-type
        opcode = 7'b0110011;
        cyc("r_reset",  1, 16'd0,             0);
        cyc("r_fetch",  1, e_fetch(1, 0),     0);
        cyc("r_decode", 1, e_decode(),        0);
        cyc("r_execr",  0, e_execr(),         0);
        cyc("r_aluwb",  1, e_aluwb(),         0);

        // lw with 2 fetch and 3 read wait cycles
        opcode = 7'b0000011;
        cyc("lw_fetch_w1", 0, e_fetch(0, 0),  1);
        cyc("lw_fetch_w2", 0, e_fetch(0, 0),  1);
        cyc("lw_fetch",    1, e_fetch(1, 0),  1);
        cyc("lw_decode",   0, e_decode(),     1);
        cyc("lw_memadr",   1, e_memadr(),     1);
        cyc("lw_rd_w1",    0, e_memread(),    1);
        cyc("lw_rd_w2",    0, e_memread(),    1);
        cyc("lw_rd_w3",    0, e_memread(),    1);
        cyc("lw_rd",       1, e_memread(),    1);
        cyc("lw_memwb",    0, e_memwb(),      1);

        // sw zero-wait
        opcode = 7'b0100011;
        cyc("sw_fetch",  1, e_fetch(1, 0),    2);
        cyc("sw_decode", 1, e_decode(),       2);
        cyc("sw_memadr", 1, e_memadr(),       2);
        cyc("sw_write",  1, e_memwrite(1),    2);

        // sw with one write wait cycle
        cyc("sw2_fetch",  1, e_fetch(1, 0),   3);
        cyc("sw2_decode", 1, e_decode(),      3);
        cyc("sw2_memadr", 1, e_memadr(),      3);
        cyc("sw2_wr_w",   0, e_memwrite(0),   3);
        cyc("sw2_write",  1, e_memwrite(1),   3);

        // beq then jal
        opcode = 7'b1100011;
        cyc("beq_fetch",  1, e_fetch(1, 0),   4);
        cyc("beq_decode", 1, e_decode(),      4);
        cyc("beq_beq",    1, e_beq(),         4);
        opcode = 7'b1101111;
        cyc("jal_fetch",  1, e_fetch(1, 0),   5);
        cyc("jal_decode", 1, e_decode(),      5);
        cyc("jal_jal",    1, e_jal(),         5);
        cyc("jal_aluwb",  1, e_aluwb(),       5);

        // I-type
        opcode = 7'b0010011;
        cyc("i_fetch",  1, e_fetch(1, 0),     6);
        cyc("i_decode", 1, e_decode(),        6);
        cyc("i_execi",  1, e_execi(),         6);
        cyc("i_aluwb",  1, e_aluwb(),         6);

        // illegal opcode: one-cycle pulse, no retire
        opcode = 7'b1111111;
        cyc("ill_fetch",  1, e_fetch(1, 0),   7);
        cyc("ill_decode", 1, e_decode(),      7);
        opcode = 7'b0000011;
        cyc("ill_pulse",  0, e_fetch(0, 1),   7);
        cyc("ill_clear",  1, e_fetch(1, 0),   7);

        // lw interrupted by reset in MEMREAD
        cyc("rst_decode", 1, e_decode(),      7);
        cyc("rst_memadr", 1, e_memadr(),      7);
        mem_ready = 1'b0;
        #1;
        chk_sig("rst_memread", e_memread());
        #2;
        rst_n = 1'b0;
        #1;
        chk_sig("rst_async", 16'd0);
        chk_cnt("rst_async", 32'd0);
        @(posedge clk);
        #1;
        chk_sig("rst_held", 16'd0);
        rst_n = 1'b1;
        cyc("rst_reset", 1, 16'd0,            0);
        cyc("rst_fetch", 1, e_fetch(1, 0),    0);
        cyc("rst_decode2", 1, e_decode(),     0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
